gain_offset_corrector: RTL
==========================

Name: gain_offset_corrector

Overview:
- Parametrised successor of the front-end saturating gain stage, sitting between the ADC sample capture and the trigger/capture RAM in the DSO datapath.
- Applies a per-channel signed offset, then a per-channel unsigned fixed-point gain.
- Saturates and rescales the result over a 3-stage valid/ready pipeline.
- Channels are time-multiplexed and tagged by a channel id that travels with each sample.

Parameters:
- DATA_W, 8, raw sample and corrected output width (unsigned).
- GAIN_W, 8, gain width (unsigned fixed-point, SHIFT fractional bits).
- OFS_W, 8, offset width (two's complement).
- SHIFT, 7, right-shift applied after multiply; unity gain = 1<<SHIFT.
- CHANNELS, 4, number of independent channel coefficient sets (>=1).
- CH_W, 2, channel id width, must satisfy 2^CH_W >= CHANNELS.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts sample this cycle.
- in_data  in  DATA_W  raw sample.
- in_ch  in  CH_W  channel id of sample.
- cfg_we  in  1  coefficient write strobe.
- cfg_ch  in  CH_W  channel being configured.
- cfg_gain  in  GAIN_W  new gain.
- cfg_offset  in  OFS_W  new offset.
- out_valid  out  1  corrected sample present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  corrected sample.
- out_ch  out  CH_W  channel id, passed through.
- out_sat  out  1  sample was clamped at any stage.

Behaviour:
- Reset (async assert, sync release): all pipeline valids 0; out_data, out_ch, out_sat 0; every channel gain = 1<<SHIFT, offset = 0.
- Transfer rules:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - adv = out_ready | ~out_valid; in_ready = adv. All stages shift together when adv = 1, otherwise all stages hold.
  - No bubble collapse. Output fields are stable while out_valid=1 and out_ready=0.
- Stage 1 (offset):
  - Computes sum = in_data + sign-extended offset[in_ch] at DATA_W+2 signed width.
  - sum<0 clamps to 0; sum>2^DATA_W-1 clamps to 2^DATA_W-1; either case sets sat1.
  - Registers gain[in_ch] alongside the sample, so later cfg writes never affect in-flight samples.
- Stage 2 (multiply): prod = sum1 * gain1, unsigned, DATA_W+GAIN_W bits. sat1 is carried.
- Stage 3 (saturate and shift):
  - prod > 2^(DATA_W+SHIFT)-1 clamps to that value and sets sat.
  - out_data = clamped >> SHIFT, truncated to DATA_W. out_sat = sat1 | stage-3 sat.
- Latency: 3 cycles from input transfer to out_valid when never stalled. Throughput 1 sample per cycle.
- Config:
  - cfg_we writes both gain and offset of cfg_ch at the clock edge, independent of the stall state.
  - A sample on the same channel accepted in the same cycle uses the old values.
  - cfg_ch >= CHANNELS: write ignored. in_ch >= CHANNELS: sample processed with channel 0 coefficients, out_ch passes the raw id.
- in_valid=1 with in_ready=0: the sample is not consumed and must be held by the source.
- Reset mid-stream: all in-flight samples are discarded and coefficients return to defaults. Nothing from before reset is ever output.

Optional Feature:
- Macro SAT_COUNT_EN.
- When defined, adds ports:
  - sat_clr  in  1  synchronous clear.
  - sat_count  out  16  output-side saturation event counter.
- sat_count increments by 1 on each output transfer with out_sat=1 and sticks at 0xFFFF.
- sat_clr has priority over a simultaneous increment (result 0). sat_count resets to 0.
- When undefined: no ports and no counter logic. Datapath behaviour is identical either way.

Test Plan:
- Reset, out_ready=1, ch0 in_data=0x64 at default coefficients -> out_data=0x64, out_ch=0, out_sat=0, exactly 3 cycles after acceptance.
- cfg ch1 gain=0xFF offset=0, send ch1 0xC8 (200*255=0xC738>0x7FFF) -> out_data=0xFF, out_sat=1. Send ch2 0x80 with ch2 gain=0x40 -> out_data=0x40, out_sat=0.
- Offset clamping:
  - ch3 offset=0xEC (-20), in_data=0x0A -> out_data=0x00, out_sat=1.
  - Offset 0x7F, in_data=0xF0 -> out_data=0xFF, out_sat=1.
- Continuous stream of 10 samples with out_ready low for 5 cycles mid-stream -> in_ready low while out_valid&~out_ready, held output stable, all 10 delivered in order with no duplicates.
- cfg write to ch0 gain=0x40 in the same cycle a ch0 0x80 sample is accepted -> that sample outputs 0x80; the next ch0 0x80 outputs 0x40.
- rst_n pulsed low with 3 samples in flight -> out_valid=0 immediately (asynchronous), none of the 3 samples appear. With SAT_COUNT_EN, 3 saturating outputs give sat_count=3, and sat_clr returns it to 0.

Source files
------------

// File: rtl/gain_offset_corrector.sv
// Per-channel offset + fixed-point gain corrector with saturation, 3-stage valid/ready pipeline.
// Optional output-side saturation event counter enabled by defining SAT_COUNT_EN.
module gain_offset_corrector #(
  parameter int DATA_W   = 8,
  parameter int GAIN_W   = 8,
  parameter int OFS_W    = 8,
  parameter int SHIFT    = 7,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [GAIN_W-1:0] cfg_gain,
  input  logic [OFS_W-1:0]  cfg_offset,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_sat
`ifdef SAT_COUNT_EN
  ,
  input  logic              sat_clr,
  output logic [15:0]       sat_count
`endif
);

  localparam int SUM_W  = DATA_W + 2;
  localparam int PROD_W = DATA_W + GAIN_W;
  localparam logic [PROD_W-1:0] PROD_MAX   = (PROD_W'(1) << (DATA_W + SHIFT)) - PROD_W'(1);
  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1) << SHIFT;
  localparam logic [DATA_W-1:0] DATA_MAX   = '1;

  logic [GAIN_W-1:0] gain_q [CHANNELS];
  logic [OFS_W-1:0]  ofs_q  [CHANNELS];

  logic              v1_q, v2_q, v3_q;
  logic [DATA_W-1:0] sum1_q, sum1_d;
  logic [GAIN_W-1:0] gain1_q;
  logic [CH_W-1:0]   ch1_q, ch2_q, ch3_q;
  logic              sat1_q, sat1_d, sat2_q, sat3_q, sat3_d;
  logic [PROD_W-1:0] prod2_q, prod2_d, clamped;
  logic [DATA_W-1:0] data3_q, data3_d;

  logic [GAIN_W-1:0]       selGain;
  logic [OFS_W-1:0]        selOfs;
  logic signed [SUM_W-1:0] sum;
  logic                    adv;

  assign adv       = out_ready | ~v3_q;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_data  = data3_q;
  assign out_ch    = ch3_q;
  assign out_sat   = sat3_q;

  // Coefficient writes ignore the stall state; writes to nonexistent channels match no entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        gain_q[c] <= GAIN_UNITY;
        ofs_q[c]  <= '0;
      end
    end else if (cfg_we) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (int'(cfg_ch) == c) begin
          gain_q[c] <= cfg_gain;
          ofs_q[c]  <= cfg_offset;
        end
      end
    end
  end

  // Out-of-range channel ids fall back to channel 0 coefficients.
  always_comb begin
    selGain = gain_q[0];
    selOfs  = ofs_q[0];
    for (int c = 1; c < CHANNELS; c++) begin
      if (int'(in_ch) == c) begin
        selGain = gain_q[c];
        selOfs  = ofs_q[c];
      end
    end
  end

  always_comb begin
    sum = $signed({2'b00, in_data}) + SUM_W'($signed(selOfs));
    sum1_d = sum[DATA_W-1:0];
    sat1_d = 1'b0;
    if (sum[SUM_W-1]) begin
      sum1_d = '0;
      sat1_d = 1'b1;
    end else if (|sum[SUM_W-2:DATA_W]) begin
      sum1_d = DATA_MAX;
      sat1_d = 1'b1;
    end
  end

  assign prod2_d = PROD_W'(sum1_q) * PROD_W'(gain1_q);

  always_comb begin
    clamped = prod2_q;
    sat3_d  = sat2_q;
    if (prod2_q > PROD_MAX) begin
      clamped = PROD_MAX;
      sat3_d  = 1'b1;
    end
    data3_d = DATA_W'(clamped >> SHIFT);
  end

  // Lock-step pipeline: every stage moves on adv, no bubble collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      sum1_q  <= '0;
      gain1_q <= '0;
      ch1_q   <= '0;
      sat1_q  <= 1'b0;
      v2_q    <= 1'b0;
      prod2_q <= '0;
      ch2_q   <= '0;
      sat2_q  <= 1'b0;
      v3_q    <= 1'b0;
      data3_q <= '0;
      ch3_q   <= '0;
      sat3_q  <= 1'b0;
    end else if (adv) begin
      v1_q    <= in_valid;
      sum1_q  <= sum1_d;
      gain1_q <= selGain;
      ch1_q   <= in_ch;
      sat1_q  <= sat1_d;
      v2_q    <= v1_q;
      prod2_q <= prod2_d;
      ch2_q   <= ch1_q;
      sat2_q  <= sat1_q;
      v3_q    <= v2_q;
      data3_q <= data3_d;
      ch3_q   <= ch2_q;
      sat3_q  <= sat3_d;
    end
  end

`ifdef SAT_COUNT_EN
  logic [15:0] satCount_q;

  assign sat_count = satCount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      satCount_q <= '0;
    end else if (sat_clr) begin
      satCount_q <= '0;
    end else if (v3_q && out_ready && sat3_q && (satCount_q != 16'hFFFF)) begin
      satCount_q <= satCount_q + 16'd1;
    end
  end
`endif

endmodule
